// File: rtl/vm_pkg.sv
// Shared types and default parameters for the vending-machine change dispenser.
package vm_pkg;

  localparam int unsigned AMT_W_DEF     = 12;
  localparam int unsigned NUM_COINS_DEF = 5;
  localparam int unsigned CNT_W_DEF     = 8;

  // Slot 0 holds the largest coin so the picker's lowest-index priority is greedy.
  localparam logic [NUM_COINS_DEF*AMT_W_DEF-1:0] COIN_VAL_DEF =
    {12'd5, 12'd10, 12'd25, 12'd50, 12'd100};

  localparam logic [CNT_W_DEF-1:0] INV_INIT_DEF = 8'd20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

endpackage

// File: rtl/vm_coin_select.sv
// Combinational priority picker: lowest in-stock slot whose value fits the residual.
module vm_coin_select #(
  parameter int unsigned AMT_W     = 12,
  parameter int unsigned NUM_COINS = 5
) (
  input  logic [AMT_W-1:0]           residual,
  input  logic [NUM_COINS*AMT_W-1:0] coin_val,
  input  logic [NUM_COINS-1:0]       in_stock,
  output logic [NUM_COINS-1:0]       sel,
  output logic                       found
);

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_COINS); i++) begin
      if (!found && in_stock[i] && (coin_val[i*AMT_W +: AMT_W] <= residual)) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vm_change_dispenser.sv
// Greedy change dispenser: one coin per ejector handshake, with per-slot inventory.
// Optional ack timeout enabled by defining VM_CHANGE_ACK_TIMEOUT_EN.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned                 AMT_W     = AMT_W_DEF,
  parameter int unsigned                 NUM_COINS = NUM_COINS_DEF,
  parameter logic [NUM_COINS*AMT_W-1:0]  COIN_VAL  = COIN_VAL_DEF,
  parameter int unsigned                 CNT_W     = CNT_W_DEF,
  parameter logic [CNT_W-1:0]            INV_INIT  = INV_INIT_DEF
`ifdef VM_CHANGE_ACK_TIMEOUT_EN
  , parameter int unsigned               ACK_TMO   = 255
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [AMT_W-1:0]              amount,
  input  logic                          inv_load,
  input  logic [$clog2(NUM_COINS)-1:0]  inv_idx,
  input  logic [CNT_W-1:0]              inv_val,
  output logic                          coin_valid,
  output logic [NUM_COINS-1:0]          coin_sel,
  input  logic                          coin_ack,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          err_jam,
  output logic [AMT_W-1:0]              residual,
  output logic [NUM_COINS*CNT_W-1:0]    inv_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_COINS);

  state_t                            state, state_nxt;
  logic [NUM_COINS-1:0][CNT_W-1:0]   inv;
  logic [NUM_COINS-1:0]              in_stock;
  logic [NUM_COINS-1:0]              pick_sel;
  logic                              pick_found;
  logic [AMT_W-1:0]                  paid_val;
  logic                              tmo_hit;

  logic                              coin_valid_d, busy_d, done_d, err_d;
  logic [NUM_COINS-1:0]              coin_sel_d;
  logic [AMT_W-1:0]                  residual_d;

  assign inv_cnt = inv;

  always_comb begin
    in_stock = '0;
    paid_val = '0;
    for (int i = 0; i < int'(NUM_COINS); i++) begin
      in_stock[i] = (inv[i] != '0);
      if (coin_sel[i]) paid_val = paid_val | COIN_VAL[i*AMT_W +: AMT_W];
    end
  end

  vm_coin_select #(
    .AMT_W     (AMT_W),
    .NUM_COINS (NUM_COINS)
  ) u_coin_select (
    .residual (residual),
    .coin_val (COIN_VAL),
    .in_stock (in_stock),
    .sel      (pick_sel),
    .found    (pick_found)
  );

`ifdef VM_CHANGE_ACK_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(ACK_TMO + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Cycles spent in EJECT; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 tmo_cnt <= '0;
    else if (state != ST_EJECT) tmo_cnt <= '0;
    else                       tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign tmo_hit = (state == ST_EJECT) && !coin_ack && (tmo_cnt == TMO_W'(ACK_TMO - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_jam <= 1'b0;
    else       err_jam <= tmo_hit;
  end
`else
  assign tmo_hit = 1'b0;
  assign err_jam = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SELECT;
      ST_SELECT: begin
        if (pick_found)           state_nxt = ST_EJECT;
        else if (residual == '0)  state_nxt = ST_DONE;
        else                      state_nxt = ST_ERROR;
      end
      ST_EJECT: begin
        if (coin_ack)     state_nxt = ST_SELECT;
        else if (tmo_hit) state_nxt = ST_ERROR;
      end
      ST_DONE:   state_nxt = ST_IDLE;
      ST_ERROR:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition being taken.
  always_comb begin
    coin_valid_d = (state_nxt == ST_EJECT);
    coin_sel_d   = '0;
    busy_d       = (state_nxt != ST_IDLE);
    done_d       = (state_nxt == ST_DONE);
    err_d        = (state_nxt == ST_ERROR);
    residual_d   = residual;
    if (state == ST_SELECT && pick_found)                coin_sel_d = pick_sel;
    else if (state == ST_EJECT && state_nxt == ST_EJECT) coin_sel_d = coin_sel;
    if (state == ST_IDLE && start)                       residual_d = amount;
    else if (state == ST_EJECT && coin_ack)              residual_d = residual - paid_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coin_valid <= 1'b0;
      coin_sel   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      residual   <= '0;
    end else begin
      coin_valid <= coin_valid_d;
      coin_sel   <= coin_sel_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      residual   <= residual_d;
    end
  end

  // Inventory: overwrite from the controller in IDLE, decrement on each acked coin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_COINS); i++) inv[i] <= INV_INIT;
    end else begin
      for (int i = 0; i < int'(NUM_COINS); i++) begin
        if (state == ST_IDLE && inv_load && inv_idx == IDX_W'(i))
          inv[i] <= inv_val;
        else if (state == ST_EJECT && coin_ack && coin_sel[i] && inv[i] != '0)
          inv[i] <= inv[i] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Randomised self-checking bench for vm_change_dispenser against a greedy payout model.
module tb_vm_change_dispenser;

  logic        clk = 1'b0;
  logic        reset, start, inv_load, coin_ack;
  logic [11:0] amount;
  logic [2:0]  inv_idx;
  logic [7:0]  inv_val;
  logic        coin_valid, busy, done, err, err_jam;
  logic [4:0]  coin_sel;
  logic [11:0] residual;
  logic [39:0] inv_cnt;

  vm_change_dispenser dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .amount     (amount),
    .inv_load   (inv_load),
    .inv_idx    (inv_idx),
    .inv_val    (inv_val),
    .coin_valid (coin_valid),
    .coin_sel   (coin_sel),
    .coin_ack   (coin_ack),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_jam    (err_jam),
    .residual   (residual),
    .inv_cnt    (inv_cnt)
  );

  always #5 clk = ~clk;

  localparam int VAL [5] = '{100, 50, 25, 10, 5};

  int          total = 0;
  int          bad   = 0;
  bit          chk_en = 1'b0;
  logic        e_valid, e_busy, e_done, e_err;
  logic [4:0]  e_sel;
  logic [11:0] e_res;
  int          m_inv [5];
  logic [4:0]  seen [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] inv_vec();
    logic [39:0] v;
    for (int i = 0; i < 5; i++) v[i*8 +: 8] = 8'(m_inv[i]);
    return v;
  endfunction

  function automatic logic [63:0] pack_seen();
    logic [63:0] p = '0;
    foreach (seen[i]) p = (p << 5) | 64'(seen[i]);
    return p;
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("coin_valid", 64'(coin_valid), 64'(e_valid));
      chk("coin_sel",   64'(coin_sel),   64'(e_sel));
      chk("busy",       64'(busy),       64'(e_busy));
      chk("done",       64'(done),       64'(e_done));
      chk("err",        64'(err),        64'(e_err));
      chk("err_jam",    64'(err_jam),    64'd0);
      chk("residual",   64'(residual),   64'(e_res));
      chk("inv_cnt",    64'(inv_cnt),    64'(inv_vec()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    e_valid = 0; e_busy = 0; e_done = 0; e_err = 0; e_sel = '0; e_res = '0;
    for (int i = 0; i < 5; i++) m_inv[i] = 20;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset  = 1'b1;
    start = 0; inv_load = 0; coin_ack = 0;
    step();
    step();
    chk("rst_valid", 64'(coin_valid), 64'd0);
    chk("rst_busy",  64'(busy),       64'd0);
    chk("rst_res",   64'(residual),   64'd0);
    chk("rst_inv",   64'(inv_cnt),    64'h14_1414_1414);
    reset = 1'b0;
    model_clear();
    chk_en = 1'b1;
  endtask

  task automatic load(input int idx, input int val);
    inv_load = 1'b1;
    inv_idx  = 3'(idx);
    inv_val  = 8'(val);
    step();
    inv_load = 1'b0;
    if (idx < 5) m_inv[idx] = val;
  endtask

  // Plans the greedy coin list up front, then drives acks with random delays.
  task automatic run_payout(input int amt, input int max_d, input bit disturb);
    int  plan [$];
    int  inv_tmp [5];
    int  res;
    int  d;
    bit  found;
    res = amt;
    for (int i = 0; i < 5; i++) inv_tmp[i] = m_inv[i];
    do begin
      found = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (!found && inv_tmp[i] > 0 && VAL[i] <= res) begin
          found = 1'b1;
          plan.push_back(i);
          inv_tmp[i]--;
          res -= VAL[i];
        end
      end
    end while (found);
    seen.delete();

    start  = 1'b1;
    amount = 12'(amt);
    step();
    start  = 1'b0;
    amount = 12'($urandom);
    e_busy = 1'b1;
    e_res  = 12'(amt);

    foreach (plan[k]) begin
      step();
      e_valid = 1'b1;
      e_sel   = 5'(1 << plan[k]);
      seen.push_back(coin_sel);
      d = $urandom_range(0, max_d);
      repeat (d) begin
        if (disturb) begin
          start    = 1'b1;
          amount   = 12'd50;
          inv_load = 1'b1;
          inv_idx  = 3'($urandom_range(0, 4));
          inv_val  = 8'($urandom);
        end
        step();
        start    = 1'b0;
        inv_load = 1'b0;
      end
      coin_ack = 1'b1;
      step();
      coin_ack = 1'b0;
      e_valid  = 1'b0;
      e_sel    = '0;
      e_res    = e_res - 12'(VAL[plan[k]]);
      m_inv[plan[k]]--;
    end

    step();
    if (res == 0) e_done = 1'b1;
    else          e_err  = 1'b1;
    step();
    e_done = 1'b0;
    e_err  = 1'b0;
    e_busy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 0; inv_load = 0; coin_ack = 0;
    amount = '0; inv_idx = '0; inv_val = '0;
    model_clear();

    do_reset();
    run_payout(85, 0, 1'b0);
    chk("t1_order", pack_seen(), 64'({5'b00010, 5'b00100, 5'b01000}));
    chk("t1_inv",   64'(inv_cnt), 64'({8'd20, 8'd19, 8'd19, 8'd19, 8'd20}));
    chk("t1_res",   64'(residual), 64'd0);

    do_reset();
    load(2, 0);
    run_payout(30, 1, 1'b0);
    chk("t2_order", pack_seen(), 64'({5'b01000, 5'b01000, 5'b01000}));
    chk("t2_dime",  64'(inv_cnt[31:24]), 64'd17);

    do_reset();
    load(3, 0);
    load(4, 0);
    run_payout(15, 1, 1'b0);
    chk("t3_ncoin", 64'(seen.size()), 64'd0);
    chk("t3_res",   64'(residual), 64'd15);

    do_reset();
    run_payout(103, 1, 1'b0);
    chk("t4_res",    64'(residual), 64'd3);
    chk("t4_dollar", 64'(inv_cnt[7:0]), 64'd19);

    do_reset();
    run_payout(85, 3, 1'b1);
    chk("t5_order", pack_seen(), 64'({5'b00010, 5'b00100, 5'b01000}));
    chk("t5_res",   64'(residual), 64'd0);

    // Reset in the middle of a coin handshake.
    start  = 1'b1;
    amount = 12'd50;
    step();
    start  = 1'b0;
    e_busy = 1'b1;
    e_res  = 12'd50;
    step();
    e_valid = 1'b1;
    e_sel   = 5'b00010;
    #5;
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("t6_valid", 64'(coin_valid), 64'd0);
    chk("t6_busy",  64'(busy),       64'd0);
    chk("t6_inv",   64'(inv_cnt),    64'h14_1414_1414);
    do_reset();

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) load($urandom_range(0, 7), $urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) run_payout($urandom_range(0, 400), 3, 1'b1);
      else                           run_payout($urandom_range(0, 80) * 5, 3, 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
